// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
//   Instruction-fetch stage plus IF/ID pipeline register. Keeps the PC, issues
//   in-order requests to instruction memory over a valid/ready interface with
//   variable latency, buffers responses in a small credit-controlled FIFO and
//   presents one instruction per cycle to ID. EX redirects flush the FIFO and
//   turn every request still in flight into a response that will be discarded.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   stall             ID cannot accept; hold the IF/ID register
//   redirect_valid    EX redirect this cycle
//   redirect_pc       redirect target (bits [1:0] ignored)
//   imem_req_valid/ready/addr   fetch request channel
//   imem_rsp_valid/data         in-order fetch responses
//   id_valid/id_pc/id_instr     IF/ID register contents
//
// Optional build macro
//   IF_PERF_CNT_EN    adds perf_fetched, perf_dropped, perf_stall_cycles
// -----------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_dropped,
    output logic [31:0] perf_stall_cycles
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW+1:0] DEPTH_W = (CW+2)'(FIFO_DEPTH);

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] out_q, out_d;        // requests accepted, response not yet seen
    logic [CW-1:0] drop_q, drop_d;      // of those, responses to throw away
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [PW-1:0] fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
    logic [PW-1:0] pcq_wr_q, pcq_wr_d, pcq_rd_q, pcq_rd_d;
    logic          id_valid_q, id_valid_d;
    logic [31:0]   id_pc_q, id_pc_d, id_instr_q, id_instr_d;

    logic [31:0] fifo_pc_q    [FIFO_DEPTH];
    logic [31:0] fifo_instr_q [FIFO_DEPTH];
    logic [31:0] pcq_q        [FIFO_DEPTH];   // PC tag of each request in flight

    logic [CW+1:0] credit_sum;
    logic          req_fire, rsp_keep, rsp_drop, id_load, fifo_pop;
    logic          unused_pc_low;

    assign unused_pc_low = ^redirect_pc[1:0];

    // Outstanding, buffered and to-be-dropped slots all consume credit, so
    // the FIFO can never overflow.
    assign credit_sum     = (CW+2)'(out_q) + (CW+2)'(fifo_cnt_q) + (CW+2)'(drop_q);
    assign imem_req_valid = !rst && !redirect_valid && (credit_sum < DEPTH_W);
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_keep       = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
    assign rsp_drop       = imem_rsp_valid && (drop_q != '0) && !redirect_valid;
    assign id_load        = !stall || !id_valid_q;
    assign fifo_pop       = id_load && (fifo_cnt_q != '0) && !redirect_valid;

    assign id_valid = id_valid_q;
    assign id_pc    = id_pc_q;
    assign id_instr = id_instr_q;

    always_comb begin
        // NOTE: every next-state variable gets a default here so no path
        // through the block leaves it unassigned, which would infer a latch.
        pc_d       = pc_q;
        out_d      = out_q;
        drop_d     = drop_q;
        fifo_cnt_d = fifo_cnt_q;
        fifo_wr_d  = fifo_wr_q;
        fifo_rd_d  = fifo_rd_q;
        pcq_wr_d   = pcq_wr_q;
        pcq_rd_d   = pcq_rd_q;
        id_valid_d = id_valid_q;
        id_pc_d    = id_pc_q;
        id_instr_d = id_instr_q;

        if (redirect_valid) begin
            // Everything still in flight becomes wrong-path, including a
            // response that is arriving right now (it is consumed and lost).
            pc_d       = {redirect_pc[31:2], 2'b00};
            drop_d     = out_q - CW'(imem_rsp_valid);
            out_d      = out_q - CW'(imem_rsp_valid);
            fifo_cnt_d = '0;
            fifo_wr_d  = '0;
            fifo_rd_d  = '0;
            pcq_wr_d   = '0;
            pcq_rd_d   = '0;
            id_valid_d = 1'b0;
            id_instr_d = NOP_INSTR;
        end else begin
            if (req_fire) begin
                pc_d     = pc_q + 32'd4;
                pcq_wr_d = pcq_wr_q + PW'(1);
            end
            out_d      = out_q + CW'(req_fire) - CW'(imem_rsp_valid);
            drop_d     = drop_q - CW'(rsp_drop);
            fifo_wr_d  = fifo_wr_q + PW'(rsp_keep);
            pcq_rd_d   = pcq_rd_q + PW'(rsp_keep);
            fifo_rd_d  = fifo_rd_q + PW'(fifo_pop);
            fifo_cnt_d = fifo_cnt_q + CW'(rsp_keep) - CW'(fifo_pop);

            if (id_load) begin
                if (fifo_cnt_q != '0) begin
                    id_valid_d = 1'b1;
                    id_pc_d    = fifo_pc_q[fifo_rd_q];
                    id_instr_d = fifo_instr_q[fifo_rd_q];
                end else begin
                    id_valid_d = 1'b0;
                    id_instr_d = NOP_INSTR;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            out_q      <= '0;
            drop_q     <= '0;
            fifo_cnt_q <= '0;
            fifo_wr_q  <= '0;
            fifo_rd_q  <= '0;
            pcq_wr_q   <= '0;
            pcq_rd_q   <= '0;
            id_valid_q <= 1'b0;
            id_pc_q    <= '0;
            id_instr_q <= NOP_INSTR;
        end else begin
            pc_q       <= pc_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            fifo_cnt_q <= fifo_cnt_d;
            fifo_wr_q  <= fifo_wr_d;
            fifo_rd_q  <= fifo_rd_d;
            pcq_wr_q   <= pcq_wr_d;
            pcq_rd_q   <= pcq_rd_d;
            id_valid_q <= id_valid_d;
            id_pc_q    <= id_pc_d;
            id_instr_q <= id_instr_d;
        end
    end

    // NOTE: storage arrays are not reset; the counters and pointers alone
    // decide which entries are meaningful.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            pcq_q[pcq_wr_q] <= pc_q;
        end
        if (rsp_keep) begin
            fifo_pc_q[fifo_wr_q]    <= pcq_q[pcq_rd_q];
            fifo_instr_q[fifo_wr_q] <= imem_rsp_data;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_dropped_q, perf_stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_dropped_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_q + 32'(rsp_keep);
            perf_dropped_q <= perf_dropped_q +
                              32'(imem_rsp_valid && (redirect_valid || drop_q != '0));
            perf_stall_q   <= perf_stall_q + 32'(stall && id_valid_q);
        end
    end

    assign perf_fetched      = perf_fetched_q;
    assign perf_dropped      = perf_dropped_q;
    assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_unit
//   Self-checking bench for if_fetch_unit. A behavioural memory returns
//   in-order responses with configurable latency; a queue-based reference
//   model of the fetch stage predicts the request channel and the IF/ID
//   register every cycle. Directed phases are followed by a random phase.
// -----------------------------------------------------------------------------
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst, stall, redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_valid;
    logic [31:0] id_pc, id_instr;

    if_fetch_unit #(
        .RESET_PC  (RESET_PC),
        .FIFO_DEPTH(DEPTH),
        .NOP_INSTR (NOP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .id_valid      (id_valid),
        .id_pc         (id_pc),
        .id_instr      (id_instr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: a request in flight is remembered with a flag telling
    // whether its response is still wanted.
    typedef struct { logic [31:0] addr; bit live; } fl_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } fe_t;
    typedef struct { logic [31:0] addr; int due; } mreq_t;

    fl_t         m_fl[$];
    fe_t         m_fifo[$];
    logic [31:0] m_pc;
    bit          m_idv;
    logic [31:0] m_idpc, m_idinstr;

    mreq_t mem_q[$];
    int    lat_min = 1, lat_max = 1, p_gap = 0;
    int    p_ready = 100, p_stall = 0, p_redir = 0, p_rst = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic bit m_req_valid();
        int dead = 0;
        foreach (m_fl[i]) if (!m_fl[i].live) dead++;
        return !rst && !redirect_valid && ((m_fl.size() + m_fifo.size() + dead) < DEPTH);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc      = RESET_PC;
        m_idv     = 1'b0;
        m_idpc    = 32'h0;
        m_idinstr = NOP;
        m_fl.delete();
        m_fifo.delete();
    endtask

    // One clock cycle: memory drives its response, outputs are checked
    // mid-cycle, the model advances, then the clock edge happens.
    task automatic cycle(input bit do_check);
        bit          exp_rv, hs;
        logic [31:0] pc0;
        fl_t         fl;
        fe_t         fe;

        if (mem_q.size() > 0 && mem_q[0].due <= cyc &&
            int'($urandom_range(99)) >= p_gap) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mem_q[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #2;
        exp_rv = m_req_valid();
        if (do_check) begin
            check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
            check("req_addr",  imem_req_addr, m_pc);
            check("id_valid",  32'(id_valid), 32'(m_idv));
            check("id_pc",     id_pc, m_idpc);
            check("id_instr",  id_instr, m_idinstr);
        end

        hs  = exp_rv && imem_req_ready;
        pc0 = m_pc;
        if (rst) begin
            model_reset();
            mem_q.delete();
        end else begin
            if (redirect_valid) begin
                if (imem_rsp_valid && m_fl.size() > 0) fl = m_fl.pop_front();
                foreach (m_fl[i]) m_fl[i].live = 1'b0;
                m_fifo.delete();
                m_idv     = 1'b0;
                m_idinstr = NOP;
                m_pc      = {redirect_pc[31:2], 2'b00};
            end else begin
                if (!stall || !m_idv) begin
                    if (m_fifo.size() > 0) begin
                        fe        = m_fifo.pop_front();
                        m_idv     = 1'b1;
                        m_idpc    = fe.pc;
                        m_idinstr = fe.instr;
                    end else begin
                        m_idv     = 1'b0;
                        m_idinstr = NOP;
                    end
                end
                if (imem_rsp_valid && m_fl.size() > 0) begin
                    fl = m_fl.pop_front();
                    if (fl.live) m_fifo.push_back('{fl.addr, imem_rsp_data});
                end
                if (hs) begin
                    m_fl.push_back('{pc0, 1'b1});
                    m_pc = pc0 + 32'd4;
                end
            end
            if (imem_rsp_valid && mem_q.size() > 0) void'(mem_q.pop_front());
            if (hs) mem_q.push_back('{pc0, cyc + int'($urandom_range(lat_max, lat_min))});
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input bit r, input bit st, input bit rv,
                         input logic [31:0] rpc, input bit rdy);
        rst            = r;
        stall          = st;
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_req_ready = rdy;
        cycle(1'b1);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            drive(int'($urandom_range(99)) < p_rst,
                  int'($urandom_range(99)) < p_stall,
                  int'($urandom_range(99)) < p_redir,
                  $urandom,
                  int'($urandom_range(99)) < p_ready);
        end
    endtask

    task automatic bound_fail(input string tag);
        errors++;
        $display("FAIL %s: wait bound expired at cyc %0d", tag, cyc);
    endtask

    initial begin
        bit reached;
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 32'h0; imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        model_reset();
        #1;
        cycle(1'b0);                           // DUT state unknown before first edge
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);  // reset values visible while rst held

        // Streaming with one-cycle memory latency.
        run(14);

        // Four stalled cycles, then resume.
        p_stall = 100; run(4);
        p_stall = 0;   run(8);

        // Redirect to 0x102 with two requests in flight.
        lat_min = 3; lat_max = 3;
        reached = 1'b0;
        for (int k = 0; k < 20 && !reached; k++) begin
            if (m_fl.size() == 2) reached = 1'b1;
            else run(1);
        end
        if (!reached) bound_fail("wait_two_outstanding");
        drive(1'b0, 1'b0, 1'b1, 32'h0000_0102, 1'b1);
        run(12);

        // Redirect in the same cycle a response arrives.
        lat_min = 2; lat_max = 2;
        reached = 1'b0;
        for (int k = 0; k < 20 && !reached; k++) begin
            if (mem_q.size() > 0 && mem_q[0].due <= cyc) reached = 1'b1;
            else run(1);
        end
        if (!reached) bound_fail("wait_rsp_redirect");
        drive(1'b0, 1'b0, 1'b1, 32'h0000_000C, 1'b1);
        lat_min = 1; lat_max = 1;
        run(10);

        // Memory refuses requests for five cycles.
        p_ready = 0;   run(5);
        p_ready = 100; run(6);

        // Reset with requests in flight and buffered data.
        lat_min = 3; lat_max = 3; p_stall = 100;
        reached = 1'b0;
        for (int k = 0; k < 30 && !reached; k++) begin
            if (m_fl.size() > 0 && m_fifo.size() > 0) reached = 1'b1;
            else run(1);
        end
        if (!reached) bound_fail("wait_busy_before_reset");
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        p_stall = 0; lat_min = 1; lat_max = 1;
        run(10);

        // Random traffic.
        lat_min = 1; lat_max = 4; p_gap = 20;
        p_ready = 70; p_stall = 30; p_redir = 6; p_rst = 1;
        run(1500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
